// File: rtl/cache_stream_reader.sv
// cache_stream_reader
//   Read-side controller for the dual-port cache RAM. An accepted start
//   issues sequential reads on the RAM read port (one-cycle registered
//   latency) and returns the words as a valid/ready stream through a
//   2-entry skid FIFO, sustaining one word per cycle without stalls.
//
// Optional feature: define CACHE_STREAM_READER_STALL_CNT_EN to add the
//   stall_cycles output (saturating count of m_valid & ~m_ready cycles).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, honoured only while busy=0
//   base_addr, length   transfer first address and word count (0..2**ADDR_WIDTH)
//   busy, done          transfer in progress / one-cycle end pulse
//   addrb, doutb        RAM read address (registered) / read data
//   m_valid, m_ready    output stream handshake
//   m_data, m_last      stream word (FIFO head) / final word marker
//   stall_cycles        (optional) back-pressure cycle counter
module cache_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef CACHE_STREAM_READER_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      issued;
  logic [LEN_W-1:0]      beat;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic accept;
  logic issue;
  logic credit_ok;
  logic last_issue;
  logic push;
  logic pop;

  assign accept     = start & ~busy;
  assign push       = inflight;
  assign pop        = m_valid & m_ready;
  assign m_valid    = (fifo_count != 2'd0);
  assign m_data     = fifo_mem[rd_ptr];
  assign m_last     = m_valid & (beat == len_q - LEN_W'(1));
  assign last_issue = (issued + LEN_W'(1) == len_q);
  // Reads already in the FIFO or in flight, less the one leaving now, must stay below the depth.
  assign credit_ok  = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; FIN behaves like IDLE so a start in the done cycle is taken
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_FIN: begin
        if (accept) state_nxt = (length == '0) ? S_FIN : S_RUN;
        else        state_nxt = S_IDLE;
      end
      S_RUN:   if (issue && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && m_last)       state_nxt = S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs and read issue
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state)
      S_RUN: begin
        busy  = 1'b1;
        issue = (issued != len_q) && credit_ok;
      end
      S_DRAIN: busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // Address/counter datapath and skid FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      addrb      <= '0;
      len_q      <= '0;
      issued     <= '0;
      beat       <= '0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
    end else begin
      inflight <= issue;

      if (accept) begin
        addrb  <= base_addr;
        len_q  <= length;
        issued <= '0;
      end else if (issue) begin
        addrb  <= addrb + ADDR_WIDTH'(1);
        issued <= issued + LEN_W'(1);
      end

      if (push) begin
        fifo_mem[wr_ptr] <= doutb;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop) rd_ptr <= ~rd_ptr;

      if (accept)   beat <= '0;
      else if (pop) beat <= beat + LEN_W'(1);

      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef CACHE_STREAM_READER_STALL_CNT_EN
  // Saturating back-pressure counter, cleared per transfer
  always_ff @(posedge clk) begin
    if (rst || accept)
      stall_cycles <= 16'h0000;
    else if (m_valid && !m_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_cache_stream_reader.sv
// Self-checking bench for cache_stream_reader: behavioural RAM, scoreboard
// of expected beats filled at start time, independent monitor on the stream.
module tb_cache_stream_reader;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef CACHE_STREAM_READER_STALL_CNT_EN
  logic [15:0]   stall_cycles;
`endif

  cache_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .addrb(addrb), .doutb(doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef CACHE_STREAM_READER_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) doutb <= ram[addrb];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Consumer ready: 0 = always, 1 = random, 2 = repeating 1,0,0
  int ready_mode = 0;
  int pat = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (pat % 3 == 0);
          pat++;
        end
      endcase
    end
  end

  // Monitor: scoreboard compare on each handshake, hold check during stalls
  int    pops = 0;
  int    dones = 0;
  int    stalls = 0;
  int    rise_cyc = -1;
  int    last_cyc = -1;
  logic  prev_valid = 1'b0;
  logic  prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  beat_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_valid = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 64'(m_valid), 64'(1));
          check("hold_data", 64'(m_data), 64'(prev_data));
        end
        if (m_valid && !prev_valid) rise_cyc = cyc;
        if (m_valid && !m_ready) stalls++;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data 0x%0h, expected no beat (cycle %0d)", m_data, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("beat_data", 64'(m_data), 64'(mon_e.data));
            check("beat_last", 64'(m_last), 64'(mon_e.last));
          end
          pops++;
          if (m_last) last_cyc = cyc;
        end
        if (done) begin
          dones++;
          check("done_busy", 64'(busy), 64'(0));
        end
        prev_valid = m_valid;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
      end
    end
  end

  // Drive a start now (busy must be 0), push the reference beats, return after E0
  task automatic issue_start(input logic [AW-1:0] b, input logic [AW:0] n, output int c0);
    beat_t         t;
    logic [AW-1:0] a;
    start     = 1'b1;
    base_addr = b;
    length    = n;
    for (int k = 0; k < int'(n); k++) begin
      a      = b + AW'(k);
      t.data = ram[a];
      t.last = (k == int'(n) - 1);
      exp_q.push_back(t);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
  endtask

  // Return in the done cycle (posedge+2); timeout counts as a failure
  task automatic wait_done(input int limit, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin
        dcyc = cyc;
        return;
      end
      @(posedge clk);
      #2;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout: no done within %0d cycles", limit);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c0, c1, d, p0, d0, s0;
    logic [AW-1:0] b;
    logic [AW:0]   n;

    for (int i = 0; i < int'(DEPTH); i++) ram[i] = DW'(i);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_addrb", 64'(addrb), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Basic transfer, exact latency and done timing
    ready_mode = 0;
    issue_start(10'h010, 11'd4, c0);
    check("t1_busy", 64'(busy), 64'(1));
    wait_done(50, d);
    check("t1_first_valid_cyc", 64'(rise_cyc), 64'(c0 + 2));
    check("t1_last_cyc", 64'(last_cyc), 64'(c0 + 5));
    check("t1_done_cyc", 64'(d), 64'(c0 + 6));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));
    idle(2);

    for (int i = 0; i < int'(DEPTH); i++) ram[i] = $urandom;

    // Address wrap
    p0 = pops;
    issue_start(10'h3FE, 11'd4, c0);
    wait_done(50, d);
    check("t2_beats", 64'(pops - p0), 64'(4));
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));
    idle(2);

    // Back-pressure pattern 1,0,0
    ready_mode = 2;
    p0 = pops;
    s0 = stalls;
    b  = AW'($urandom);
    issue_start(b, 11'd8, c0);
    wait_done(200, d);
    check("t3_beats", 64'(pops - p0), 64'(8));
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));
    check("t3_saw_stalls", 64'(stalls - s0 > 0), 64'(1));
`ifdef CACHE_STREAM_READER_STALL_CNT_EN
    check("t3_stall_cycles", 64'(stall_cycles), 64'(stalls - s0));
`endif
    ready_mode = 0;
    idle(2);

    // Zero length
    d0 = dones;
    p0 = pops;
    issue_start(AW'($urandom), 11'd0, c0);
    check("t4_busy", 64'(busy), 64'(0));
    wait_done(5, d);
    check("t4_done_cyc", 64'(d), 64'(c0));
    idle(3);
    check("t4_one_done", 64'(dones - d0), 64'(1));
    check("t4_no_beats", 64'(pops - p0), 64'(0));
    check("t4_busy_after", 64'(busy), 64'(0));

    // Reset mid-transfer after 3 beats
    p0 = pops;
    issue_start(AW'($urandom), 11'd10, c0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge clk);
        #2;
        if (pops - p0 >= 3) seen = 1'b1;
      end
      check("t5_three_beats", 64'(seen), 64'(1));
    end
    rst = 1'b1;
    d0  = dones;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", 64'(m_valid), 64'(0));
    check("t5_busy_after_rst", 64'(busy), 64'(0));
    idle(3);
    check("t5_no_done", 64'(dones - d0), 64'(0));
    issue_start(AW'($urandom), 11'd2, c0);
    wait_done(50, d);
    check("t5_restart_first_cyc", 64'(rise_cyc), 64'(c0 + 2));
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));
    idle(2);

    // Start while busy is ignored; start in done cycle is accepted
    issue_start(AW'($urandom), 11'd6, c0);
    start = 1'b1;
    base_addr = AW'($urandom);
    length = 11'd5;
    idle(2);
    start = 1'b0;
    wait_done(100, d);
    issue_start(AW'($urandom), 11'd3, c1);
    check("t6_accept_in_done", 64'(busy), 64'(1));
    wait_done(50, d);
    check("t6_first_valid_cyc", 64'(rise_cyc), 64'(c1 + 2));
    check("t6_queue_empty", 64'(exp_q.size()), 64'(0));
    idle(2);

    // Random transfers with random back-pressure
    ready_mode = 1;
    for (int t = 0; t < 10; t++) begin
      b = AW'($urandom);
      n = (t % 4 == 3) ? 11'd0 : 11'($urandom_range(1, 24));
      issue_start(b, n, c0);
      wait_done(400, d);
      check("rand_queue_empty", 64'(exp_q.size()), 64'(0));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    ready_mode = 0;
    idle(3);

    // Whole RAM in one transfer
    p0 = pops;
    issue_start(AW'($urandom), 11'(DEPTH), c0);
    wait_done(DEPTH + 100, d);
    check("full_done_cyc", 64'(d), 64'(c0 + int'(DEPTH) + 2));
    check("full_beats", 64'(pops - p0), 64'(DEPTH));
    check("full_queue_empty", 64'(exp_q.size()), 64'(0));
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_stream_reader.md
# cache_stream_reader

Read-side controller for the team's dual-port `cache` RAM. On a `start` command it issues sequential reads on the RAM's read port (`addrb`/`doutb`, one-cycle registered latency). It returns the words as a valid/ready stream, with a 2-entry skid FIFO so back-pressure never loses data. It sits between the cache and any downstream consumer (e.g. the PE array feeder) and sustains one word per cycle when the consumer never stalls.

## Interface
- `DATA_WIDTH`, 32, width of RAM words and stream data
- `ADDR_WIDTH`, 10, RAM address width; the RAM holds 2**ADDR_WIDTH words

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; sampled only while `busy`=0
- `base_addr`  in  ADDR_WIDTH  first word address, captured on accepted `start`
- `length`  in  ADDR_WIDTH+1  number of words (0 to 2**ADDR_WIDTH), captured on accepted `start`
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse at end of transfer
- `addrb`  out  ADDR_WIDTH  RAM read address, driven from a register
- `doutb`  in  DATA_WIDTH  RAM read data, valid one cycle after `addrb`
- `m_valid`  out  1  stream word available
- `m_ready`  in  1  consumer accepts word
- `m_data`  out  DATA_WIDTH  stream word (FIFO head)
- `m_last`  out  1  high with the final word of the transfer

## Operation
- FSM states:
  - IDLE
    - `start`=1 and `length`≠0 → RUN: latch base/length.
    - `start`=1 and `length`=0 → FIN.
  - RUN
    - Issues reads.
    - → DRAIN when the issued count equals `length`.
  - DRAIN
    - Waits until the FIFO is empty and the final beat handshakes.
    - Then → FIN.
  - FIN
    - `done`=1 for this one cycle, `busy`=0.
    - → IDLE, or directly accepts a new `start` in this cycle.
- `busy`=1 in RUN and DRAIN only.
- `start` is ignored while `busy`=1.
- Read issue, in RUN only: at most one read per cycle, when `fifo_count + inflight - pop < 2`, with `pop = m_valid & m_ready`.
- Each issued read advances `addrb` by 1, modulo 2**ADDR_WIDTH. Wrap from 2**ADDR_WIDTH-1 to 0 is legal.
- `doutb` is pushed into the FIFO one cycle after its read was issued (`inflight` flag).
- The credit rule guarantees the FIFO never overflows.
- A simultaneous push and pop keeps the count unchanged.
- `m_data` and `m_valid` come from the FIFO head. `m_data` is held stable while `m_valid`=1 and `m_ready`=0.
- `m_last` = `m_valid` and head is word number `length`-1. It is tracked by a beat counter of width ADDR_WIDTH+1.
- `length`=2**ADDR_WIDTH reads the whole RAM once, starting at `base_addr`.
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `addrb`=0, FSM=IDLE, counters=0.
- `rst` mid-transfer:
  - Flushes the FIFO and drops any in-flight read.
  - `m_valid` is low in the cycle after the reset edge.
  - No `done` pulse is generated.

## Timing
- Cycle 0: `start` sampled high at edge E0.
- From E0: `addrb`=`base_addr`; read issued at E1.
- Data pushed at E2: `m_valid`=1 after E2. Start-to-first-word latency is 2 cycles.
- With `m_ready` held high, word k appears after edge E(2+k); throughput is 1 word/cycle.
- The last beat handshakes at edge Ex; `done`=1 and `busy`=0 during the cycle after Ex.
- `length`=0: `done` pulses in the cycle after E0; no beats are produced.
- After `m_ready` is deasserted, at most 2 further reads complete before issue stalls. Issue resumes in the same cycle `m_ready` returns.

## Configuration
- `CACHE_STREAM_READER_STALL_CNT_EN` defined:
  - Adds output `stall_cycles` [15:0].
  - It is cleared on accepted `start` and on `rst`.
  - It increments each cycle with `m_valid`=1 and `m_ready`=0, and saturates at 16'hFFFF.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- `base_addr`=0x010, `length`=4, `m_ready`=1, RAM[i]=i → beats 0x10..0x13 on 4 consecutive cycles starting 2 cycles after `start`; `m_last` on 0x13; `done` 1 cycle later.
- `base_addr`=0x3FE, `length`=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001 in order; no duplicate or lost word.
- `length`=8 with `m_ready` toggling 1,0,0,1,… → all 8 words delivered exactly once and in order; `m_data` stable during stalls; with the macro defined, `stall_cycles` equals the counted stall cycles.
- `length`=0 → no `m_valid`; `done` pulse in the cycle after `start`; `busy` stays 0.
- `rst` asserted while 3 of 10 words are delivered → next cycle `m_valid`=0 and `busy`=0, no `done`; a following `start` with `length`=2 delivers correct data.
- `start` pulsed while `busy`=1 → ignored; a `start` in the `done` cycle is accepted and its first beat arrives 2 cycles later.
